mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 163 ++++++++++++++++
 tb/tb_mem_access.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: holds one instruction, issues data-memory requests, extracts load data.
// Optional MEM_ADDR_EXC_EN: misaligned half/word accesses raise address errors instead of being issued.
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        exe_valid,
  input  logic        exe_load,
  input  logic        exe_store,
  input  logic [1:0]  exe_size,
  input  logic        exe_sign,
  input  logic [31:0] exe_addr,
  input  logic [31:0] exe_wdata,
  input  logic [31:0] exe_result,
  input  logic        exe_wen,
  input  logic [4:0]  exe_wdest,
  input  logic [31:0] exe_pc,
  output logic        mem_allowin,
  output logic        dm_req,
  output logic        dm_wr,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  input  logic        wb_allowin,
  input  logic        cancel,
  output logic        wb_valid,
  output logic [31:0] wb_result,
  output logic        wb_wen,
  output logic [4:0]  wb_wdest,
  output logic [31:0] wb_pc,
  output logic        wb_raddr_err,
  output logic        wb_waddr_err,
  output logic [31:0] wb_badaddr,
  output logic [4:0]  MEM_wdest
);

  localparam logic [2:0] S_EMPTY = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  typedef struct packed {
    logic        load;
    logic        store;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  logic [2:0]  state, state_nxt;
  mreq_t       hold;
  logic        accept;
  logic        misalign;
  logic        raddr_err, waddr_err;
  logic [31:0] rshift, ld_data;

  assign misalign = (exe_size == 2'd1 && exe_addr[0]) ||
                    (exe_size == 2'd2 && exe_addr[1:0] != 2'b00);
`ifdef MEM_ADDR_EXC_EN
  assign raddr_err = exe_load  & misalign;
  assign waddr_err = exe_store & misalign;
`else
  assign raddr_err = 1'b0;
  assign waddr_err = 1'b0;
`endif

  assign mem_allowin = !cancel && (state == S_EMPTY || (state == S_DONE && wb_allowin));
  assign accept      = exe_valid && mem_allowin;

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: state_nxt = S_EMPTY;
      S_REQ:   if (dm_gnt) state_nxt = hold.store ? S_DONE : S_WAIT;
      S_WAIT:  if (dm_rvalid) state_nxt = S_DONE;
      S_DONE:  if (wb_allowin) state_nxt = S_EMPTY;
      S_DRAIN: if (dm_rvalid) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
    // A new accept can only happen from EMPTY or a retiring DONE, so it overrides the above
    if (accept)
      state_nxt = ((exe_load || exe_store) && !raddr_err && !waddr_err) ? S_REQ : S_DONE;
    if (cancel) begin
      case (state)
        S_WAIT:  state_nxt = S_DRAIN;
        S_DRAIN: state_nxt = dm_rvalid ? S_EMPTY : S_DRAIN;
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_EMPTY;
    else       state <= state_nxt;
  end

  // Load lane extraction; misaligned halves simply take whatever lies above the lane
  assign rshift = dm_rdata >> {hold.addr[1:0], 3'b000};
  always_comb begin
    case (hold.size)
      2'd0:    ld_data = {{24{hold.sign & rshift[7]}},  rshift[7:0]};
      2'd1:    ld_data = {{16{hold.sign & rshift[15]}}, rshift[15:0]};
      default: ld_data = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold         <= '0;
      wb_result    <= '0;
      wb_wen       <= 1'b0;
      wb_wdest     <= '0;
      wb_pc        <= '0;
      wb_raddr_err <= 1'b0;
      wb_waddr_err <= 1'b0;
      wb_badaddr   <= '0;
    end else if (accept) begin
      hold         <= '{load: exe_load, store: exe_store, size: exe_size,
                        sign: exe_sign, addr: exe_addr, wdata: exe_wdata};
      wb_result    <= exe_result;
      wb_wen       <= exe_wen;
      wb_wdest     <= exe_wdest;
      wb_pc        <= exe_pc;
      wb_raddr_err <= raddr_err;
      wb_waddr_err <= waddr_err;
      wb_badaddr   <= (raddr_err || waddr_err) ? exe_addr : 32'd0;
    end else if (state == S_WAIT && dm_rvalid && !cancel) begin
      wb_result    <= ld_data;
    end
  end

  always_comb begin
    dm_req   = (state == S_REQ) && !cancel;
    dm_wr    = dm_req & hold.store;
    dm_addr  = dm_req ? {hold.addr[31:2], 2'b00} : 32'd0;
    dm_be    = 4'b0000;
    dm_wdata = 32'd0;
    if (dm_req) begin
      case (hold.size)
        2'd0: begin
          dm_be    = 4'b0001 << hold.addr[1:0];
          dm_wdata = {4{hold.wdata[7:0]}};
        end
        2'd1: begin
          dm_be    = 4'b0011 << hold.addr[1:0];
          dm_wdata = {2{hold.wdata[15:0]}};
        end
        default: begin
          dm_be    = 4'b1111;
          dm_wdata = hold.wdata;
        end
      endcase
    end
  end

  assign wb_valid  = (state == S_DONE);
  assign MEM_wdest = (state == S_EMPTY || state == S_DRAIN) ? 5'd0 : wb_wdest;

endmodule

// File: tb/tb_mem_access.sv
// Directed test of mem_access: ALU pass-through, loads/stores, misalignment, cancel/drain and async reset.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        reset;
  logic        exe_valid, exe_load, exe_store, exe_sign, exe_wen;
  logic [1:0]  exe_size;
  logic [31:0] exe_addr, exe_wdata, exe_result, exe_pc;
  logic [4:0]  exe_wdest;
  logic        mem_allowin, dm_req, dm_wr, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        wb_allowin, cancel, wb_valid, wb_wen, wb_raddr_err, wb_waddr_err;
  logic [31:0] wb_result, wb_pc, wb_badaddr;
  logic [4:0]  wb_wdest, MEM_wdest;

  int n_chk = 0;
  int n_fail = 0;

  mem_access dut (
    .clk(clk), .reset(reset),
    .exe_valid(exe_valid), .exe_load(exe_load), .exe_store(exe_store), .exe_size(exe_size),
    .exe_sign(exe_sign), .exe_addr(exe_addr), .exe_wdata(exe_wdata), .exe_result(exe_result),
    .exe_wen(exe_wen), .exe_wdest(exe_wdest), .exe_pc(exe_pc),
    .mem_allowin(mem_allowin),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .wb_allowin(wb_allowin), .cancel(cancel),
    .wb_valid(wb_valid), .wb_result(wb_result), .wb_wen(wb_wen), .wb_wdest(wb_wdest),
    .wb_pc(wb_pc), .wb_raddr_err(wb_raddr_err), .wb_waddr_err(wb_waddr_err),
    .wb_badaddr(wb_badaddr), .MEM_wdest(MEM_wdest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] res,
                       input logic [4:0] dst);
    exe_valid = 1'b1; exe_load = ld; exe_store = st; exe_size = sz; exe_sign = sg;
    exe_addr = a; exe_wdata = wd; exe_result = res; exe_wen = 1'b1; exe_wdest = dst;
    exe_pc = 32'h8000_0000 | a;
  endtask

  initial begin
    reset = 1'b1; exe_valid = 0; exe_load = 0; exe_store = 0; exe_size = 0; exe_sign = 0;
    exe_addr = 0; exe_wdata = 0; exe_result = 0; exe_wen = 0; exe_wdest = 0; exe_pc = 0;
    dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0; wb_allowin = 1; cancel = 0;
    #12;
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_wb_result", wb_result, 32'd0);
    chk("rst_allowin", {31'd0, mem_allowin}, 32'd1);
    reset = 1'b0;
    tick();

    // ALU ops back to back
    drive(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h1234_5678, 5'd5);
    tick();
    chk("alu1_valid", {31'd0, wb_valid}, 32'd1);
    chk("alu1_result", wb_result, 32'h1234_5678);
    chk("alu1_memwdest", {27'd0, MEM_wdest}, 32'd5);
    chk("alu1_allowin", {31'd0, mem_allowin}, 32'd1);
    drive(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd6);
    tick();
    chk("alu2_valid", {31'd0, wb_valid}, 32'd1);
    chk("alu2_result", wb_result, 32'hCAFE_F00D);
    exe_valid = 0;
    tick();
    chk("alu_empty_valid", {31'd0, wb_valid}, 32'd0);
    chk("alu_empty_memwdest", {27'd0, MEM_wdest}, 32'd0);

    // Back-pressure holds outputs
    drive(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'hAAAA_5555, 5'd7);
    tick();
    wb_allowin = 0;
    drive(0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h1111_1111, 5'd8);
    #1;
    chk("bp_allowin", {31'd0, mem_allowin}, 32'd0);
    tick();
    chk("bp_valid", {31'd0, wb_valid}, 32'd1);
    chk("bp_result", wb_result, 32'hAAAA_5555);
    wb_allowin = 1; exe_valid = 0;
    tick();
    chk("bp_drain", {31'd0, wb_valid}, 32'd0);

    // LB signed, grant after 2 cycles
    drive(1, 0, 2'd0, 1, 32'h0000_1003, 32'h0, 32'h0, 5'd9);
    tick();
    exe_valid = 0;
    chk("lb_req", {31'd0, dm_req}, 32'd1);
    chk("lb_wr", {31'd0, dm_wr}, 32'd0);
    chk("lb_addr", dm_addr, 32'h0000_1000);
    chk("lb_allowin", {31'd0, mem_allowin}, 32'd0);
    tick();
    chk("lb_req_hold", {31'd0, dm_req}, 32'd1);
    tick();
    dm_gnt = 1;
    tick();
    dm_gnt = 0;
    chk("lb_wait_req", {31'd0, dm_req}, 32'd0);
    chk("lb_wait_valid", {31'd0, wb_valid}, 32'd0);
    dm_rvalid = 1; dm_rdata = 32'h80FF_FF00;
    tick();
    dm_rvalid = 0;
    chk("lb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lb_result", wb_result, 32'hFFFF_FF80);
    tick();

    // LHU upper half
    drive(1, 0, 2'd1, 0, 32'h0000_1002, 32'h0, 32'h0, 5'd10);
    tick();
    exe_valid = 0; dm_gnt = 1;
    tick();
    dm_gnt = 0; dm_rvalid = 1; dm_rdata = 32'h80FF_FF00;
    tick();
    dm_rvalid = 0;
    chk("lhu_result", wb_result, 32'h0000_80FF);
    tick();

    // SH lane 2
    drive(0, 1, 2'd1, 0, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 5'd0);
    tick();
    exe_valid = 0;
    chk("sh_req", {31'd0, dm_req}, 32'd1);
    chk("sh_wr", {31'd0, dm_wr}, 32'd1);
    chk("sh_be", {28'd0, dm_be}, 32'h0000_000C);
    chk("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", dm_addr, 32'h0000_2000);
    dm_gnt = 1;
    tick();
    dm_gnt = 0;
    chk("sh_done", {31'd0, wb_valid}, 32'd1);
    chk("sh_done_req", {31'd0, dm_req}, 32'd0);
    tick();

    // SB lane 1
    drive(0, 1, 2'd0, 0, 32'h0000_2001, 32'h0000_00A5, 32'h0, 5'd0);
    tick();
    exe_valid = 0;
    chk("sb_be", {28'd0, dm_be}, 32'h0000_0002);
    chk("sb_wdata", dm_wdata, 32'hA5A5_A5A5);
    dm_gnt = 1;
    tick();
    dm_gnt = 0;
    tick();

    // Misaligned LW
    drive(1, 0, 2'd2, 0, 32'h0000_3001, 32'h0, 32'h0, 5'd11);
    tick();
    exe_valid = 0;
`ifdef MEM_ADDR_EXC_EN
    chk("lwx_req", {31'd0, dm_req}, 32'd0);
    chk("lwx_valid", {31'd0, wb_valid}, 32'd1);
    chk("lwx_rerr", {31'd0, wb_raddr_err}, 32'd1);
    chk("lwx_badaddr", wb_badaddr, 32'h0000_3001);
`else
    chk("lwm_req", {31'd0, dm_req}, 32'd1);
    chk("lwm_addr", dm_addr, 32'h0000_3000);
    dm_gnt = 1;
    tick();
    dm_gnt = 0; dm_rvalid = 1; dm_rdata = 32'h1122_3344;
    tick();
    dm_rvalid = 0;
    chk("lwm_result", wb_result, 32'h1122_3344);
    chk("lwm_rerr", {31'd0, wb_raddr_err}, 32'd0);
    chk("lwm_badaddr", wb_badaddr, 32'd0);
`endif
    tick();

    // Cancel in WAIT, rvalid two cycles later is drained
    drive(1, 0, 2'd2, 0, 32'h0000_4000, 32'h0, 32'h0, 5'd12);
    tick();
    exe_valid = 0; dm_gnt = 1;
    tick();
    dm_gnt = 0; cancel = 1;
    tick();
    cancel = 0;
    chk("drain_valid", {31'd0, wb_valid}, 32'd0);
    chk("drain_allowin", {31'd0, mem_allowin}, 32'd0);
    tick();
    chk("drain_allowin2", {31'd0, mem_allowin}, 32'd0);
    dm_rvalid = 1; dm_rdata = 32'hDEAD_BEEF;
    tick();
    dm_rvalid = 0;
    chk("drain_done_allowin", {31'd0, mem_allowin}, 32'd1);
    chk("drain_done_valid", {31'd0, wb_valid}, 32'd0);
    chk("drain_result", wb_result, 32'h0000_0000);

    // Cancel in REQ withdraws the request at once
    drive(1, 0, 2'd2, 0, 32'h0000_5000, 32'h0, 32'h0, 5'd13);
    tick();
    exe_valid = 0; cancel = 1;
    #1;
    chk("creq_req", {31'd0, dm_req}, 32'd0);
    chk("creq_allowin", {31'd0, mem_allowin}, 32'd0);
    tick();
    cancel = 0;
    #1;
    chk("creq_empty", {31'd0, mem_allowin}, 32'd1);
    chk("creq_valid", {31'd0, wb_valid}, 32'd0);

    // Async reset in REQ, then a stale rvalid
    drive(1, 0, 2'd2, 0, 32'h0000_6000, 32'h0, 32'h0, 5'd14);
    tick();
    exe_valid = 0;
    chk("rreq_req", {31'd0, dm_req}, 32'd1);
    #1 reset = 1;
    #1;
    chk("rreq_req_off", {31'd0, dm_req}, 32'd0);
    chk("rreq_addr", dm_addr, 32'd0);
    chk("rreq_valid", {31'd0, wb_valid}, 32'd0);
    chk("rreq_wdest", {27'd0, wb_wdest}, 32'd0);
    tick();
    reset = 0;
    dm_rvalid = 1; dm_rdata = 32'h5555_AAAA;
    tick();
    dm_rvalid = 0;
    chk("late_valid", {31'd0, wb_valid}, 32'd0);
    chk("late_allowin", {31'd0, mem_allowin}, 32'd1);
    chk("late_result", wb_result, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
